// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router (FSM, synchronizer, register block, FIFO).
// Latency: none, declarations only.
// Backpressure: not applicable.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    // Packet-control FSM state encoding, 3 bits, all 8 codes assigned.
    typedef logic [2:0] state_t;

    localparam state_t DECODE_ADDRESS     = 3'd0;
    localparam state_t LOAD_FIRST_DATA    = 3'd1;
    localparam state_t LOAD_DATA          = 3'd2;
    localparam state_t FIFO_FULL_STATE    = 3'd3;
    localparam state_t LOAD_AFTER_FULL    = 3'd4;
    localparam state_t LOAD_PARITY        = 3'd5;
    localparam state_t CHECK_PARITY_ERROR = 3'd6;
    localparam state_t WAIT_TILL_EMPTY    = 3'd7;

    // Pick one per-port flag by destination; the invalid address selects nothing.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] flags,
                                      input logic [ADDR_W-1:0]    addr);
        logic r;
        r = 1'b0;
        case (addr)
            2'd0:    r = flags[0];
            2'd1:    r = flags[1];
            2'd2:    r = flags[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-control FSM of the 1x3 router: decodes the header, sequences header/payload/parity loads.
// Latency: Moore machine, outputs decode from the state register with no extra delay.
// Backpressure: busy holds the source during header load, full stall, parity and busy-destination wait.
module router_fsm
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] din,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    output logic              busy,
    output logic              detect_addr,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg
);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] tgt;

    logic [NUM_PORTS-1:0] fifo_empty_vec;
    logic [NUM_PORTS-1:0] soft_reset_vec;
    logic                 empty_din;
    logic                 empty_tgt;
    logic                 soft_reset_tgt;

    assign fifo_empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_reset_vec = {soft_reset_2, soft_reset_1, soft_reset_0};

    // The header decision looks at the live address; later states use the latched target.
    assign empty_din      = port_sel(fifo_empty_vec, din);
    assign empty_tgt      = port_sel(fifo_empty_vec, tgt);
    assign soft_reset_tgt = port_sel(soft_reset_vec, tgt);

    // State register and destination latch; reset discards any packet in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DECODE_ADDRESS;
            tgt   <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && pkt_valid) begin
                tgt <= din;
            end
        end
    end

    // Next-state logic; a soft reset on the target port aborts the packet from any active state.
    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && din != INVALID_ADDR) begin
                    next_state = empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    next_state = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    next_state = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_tgt) begin
                    next_state = LOAD_FIRST_DATA;
                end
            end
            default: next_state = DECODE_ADDRESS;
        endcase

        if (state != DECODE_ADDRESS && soft_reset_tgt) begin
            next_state = DECODE_ADDRESS;
        end
    end

    // Moore output decode; anything not named for a state stays low.
    always_comb begin
        busy          = 1'b0;
        detect_addr   = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        case (state)
            DECODE_ADDRESS: detect_addr = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            WAIT_TILL_EMPTY: busy = 1'b1;
            default: detect_addr = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm.
// Latency: outputs checked 1 time unit after each rising clk edge.
// Backpressure: busy is checked as part of every output vector.
module tb_router_fsm;

    logic       clk;
    logic       rst;
    logic       pkt_valid;
    logic [1:0] din;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       busy, detect_addr, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg;

    int passed;
    int total;

    // Output vector order: busy, detect_addr, lfd, ld, laf, full, write_enb, rst_int
    localparam logic [7:0] E_DA   = 8'b0100_0000;
    localparam logic [7:0] E_LFD  = 8'b1010_0000;
    localparam logic [7:0] E_LD   = 8'b0001_0010;
    localparam logic [7:0] E_FULL = 8'b1000_0100;
    localparam logic [7:0] E_LAF  = 8'b1000_1010;
    localparam logic [7:0] E_LP   = 8'b1000_0010;
    localparam logic [7:0] E_CPE  = 8'b1000_0001;
    localparam logic [7:0] E_WTE  = 8'b1000_0000;

    logic [7:0] outs;
    assign outs = {busy, detect_addr, lfd_state, ld_state, laf_state,
                   full_state, write_enb_reg, rst_int_reg};

    router_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .din           (din),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .busy          (busy),
        .detect_addr   (detect_addr),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        total++;
        assert (outs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, outs, exp);
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        rst           = 1'b0;
        pkt_valid     = 1'b0;
        din           = 2'b00;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        fifo_full     = 1'b0;
        fifo_empty_0  = 1'b1;
        fifo_empty_1  = 1'b1;
        fifo_empty_2  = 1'b1;
        soft_reset_0  = 1'b0;
        soft_reset_1  = 1'b0;
        soft_reset_2  = 1'b0;

        // Reset for two clocks, then idle
        step(); check("reset_1", E_DA);
        step(); check("reset_2", E_DA);
        rst = 1'b1;
        step(); check("idle", E_DA);

        // Normal 3-byte packet to port 1
        din = 2'b01; pkt_valid = 1'b1;
        step(); check("norm_lfd", E_LFD);
        step(); check("norm_ld1", E_LD);
        step(); check("norm_ld2", E_LD);
        step(); check("norm_ld3", E_LD);
        pkt_valid = 1'b0;
        step(); check("norm_lp", E_LP);
        step(); check("norm_cpe", E_CPE);
        step(); check("norm_da", E_DA);

        // Full stall during the second payload cycle, LAF returns to LD
        pkt_valid = 1'b1;
        step(); check("full_lfd", E_LFD);
        step(); check("full_ld1", E_LD);
        step(); check("full_ld2", E_LD);
        fifo_full = 1'b1;
        step(); check("full_st1", E_FULL);
        step(); check("full_st2", E_FULL);
        step(); check("full_st3", E_FULL);
        fifo_full = 1'b0;
        step(); check("full_laf", E_LAF);
        step(); check("full_laf_ld", E_LD);

        // Second stall, low_pkt_valid in LAF leads to parity
        fifo_full = 1'b1;
        step(); check("full2_st", E_FULL);
        fifo_full = 1'b0; pkt_valid = 1'b0; low_pkt_valid = 1'b1;
        step(); check("full2_laf", E_LAF);
        step(); check("full2_lp", E_LP);
        low_pkt_valid = 1'b0;
        // CPE with FIFO full goes back to the stall state
        step(); check("full2_cpe", E_CPE);
        fifo_full = 1'b1;
        step(); check("cpe_to_full", E_FULL);
        fifo_full = 1'b0;
        step(); check("cpe_full_laf", E_LAF);
        parity_done = 1'b1;
        step(); check("laf_parity_done", E_DA);
        parity_done = 1'b0;

        // fifo_full has priority over pkt_valid falling in LD
        pkt_valid = 1'b1;
        step(); check("prio_lfd", E_LFD);
        step(); check("prio_ld", E_LD);
        pkt_valid = 1'b0; fifo_full = 1'b1;
        step(); check("prio_full", E_FULL);
        fifo_full = 1'b0;
        step(); check("prio_laf", E_LAF);
        low_pkt_valid = 1'b1;
        step(); check("prio_lp", E_LP);
        low_pkt_valid = 1'b0;
        step(); check("prio_cpe", E_CPE);
        step(); check("prio_da", E_DA);

        // Busy destination port 2; din changes mid-wait so only the latched target counts
        din = 2'b10; fifo_empty_2 = 1'b0; pkt_valid = 1'b1;
        step(); check("wte_1", E_WTE);
        din = 2'b00;
        step(); check("wte_2", E_WTE);
        step(); check("wte_3", E_WTE);
        step(); check("wte_4", E_WTE);
        step(); check("wte_5", E_WTE);
        fifo_empty_2 = 1'b1;
        step(); check("wte_lfd", E_LFD);
        step(); check("wte_ld", E_LD);
        pkt_valid = 1'b0;
        step(); check("wte_lp", E_LP);
        step(); check("wte_cpe", E_CPE);
        step(); check("wte_da", E_DA);

        // Invalid address is dropped
        din = 2'b11; pkt_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); check("invalid_addr", E_DA);
        end
        pkt_valid = 1'b0;

        // Soft reset: non-target port ignored, target port aborts
        din = 2'b00; pkt_valid = 1'b1;
        step(); check("sr_lfd", E_LFD);
        step(); check("sr_ld", E_LD);
        soft_reset_2 = 1'b1;
        step(); check("sr_other_port", E_LD);
        soft_reset_2 = 1'b0; soft_reset_0 = 1'b1; pkt_valid = 1'b0;
        step(); check("sr_target_abort", E_DA);
        soft_reset_0 = 1'b0;
        step(); check("sr_idle", E_DA);

        // Soft reset on the target while waiting for a busy FIFO
        din = 2'b01; fifo_empty_1 = 1'b0; pkt_valid = 1'b1;
        step(); check("sr_wte", E_WTE);
        pkt_valid = 1'b0; soft_reset_1 = 1'b1;
        step(); check("sr_wte_abort", E_DA);
        soft_reset_1 = 1'b0; fifo_empty_1 = 1'b1;

        // Synchronous reset in LAF discards the packet
        pkt_valid = 1'b1;
        step(); check("rst_lfd", E_LFD);
        step(); check("rst_ld", E_LD);
        fifo_full = 1'b1;
        step(); check("rst_full", E_FULL);
        fifo_full = 1'b0;
        step(); check("rst_laf", E_LAF);
        rst = 1'b0; pkt_valid = 1'b0;
        step(); check("rst_in_laf", E_DA);
        rst = 1'b1;
        step(); check("rst_after", E_DA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
